// File: rtl/adc_stream_capture.sv
// ---------------------------------------------------------------------------
// adc_stream_capture
//
// Multi-channel ADC capture engine. It takes per-sample-instant ADC words,
// decimates them and packs them into TDATA_W-bit beats. The beats are framed
// with tlast and queued in a first-word-fall-through output FIFO that drives
// an AXI-Stream master.
//
// Ports
//   sys_clk, sys_rst    system clock, asynchronous active-high reset
//   ad_data, ad_valid   one sample instant (all channels) per valid cycle
//   start, stop         capture control pulses
//   cont, trig_mode,    configuration, latched by an accepted start
//   decim, frame_len
//   trig_in             external trigger, synchronous to sys_clk
//   m_axis_*            AXI-Stream master (tdata, tvalid, tready, tlast)
//   busy                capture FSM is not idle
//   overflow            sticky FIFO overflow flag, cleared by start
//   frame_cnt           frames completed since the last start
// ---------------------------------------------------------------------------
module adc_stream_capture #(
  parameter int CH_NUM     = 2,
  parameter int SAMPLE_W   = 12,
  parameter int TDATA_W    = 64,
  parameter int FIFO_DEPTH = 512,
  parameter int LEN_W      = 16
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic [CH_NUM*SAMPLE_W-1:0] ad_data,
  input  logic                       ad_valid,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       cont,
  input  logic                       trig_mode,
  input  logic                       trig_in,
  input  logic [7:0]                 decim,
  input  logic [LEN_W-1:0]           frame_len,
  output logic [TDATA_W-1:0]         m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic                       busy,
  output logic                       overflow,
  output logic [15:0]                frame_cnt
);

  // Sample instants packed into one beat.
  localparam int K      = TDATA_W / (16 * CH_NUM);
  localparam int SLOT_W = (K > 1) ? $clog2(K) : 1;
  localparam int AW     = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    CAPT = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Latched configuration
  logic             cont_reg;
  logic             trig_mode_reg;
  logic [7:0]       decim_reg;
  logic [LEN_W-1:0] frame_len_reg;

  logic             trig_prev_reg;
  logic [7:0]       dec_cnt_reg;
  logic [LEN_W-1:0] inst_cnt_reg;
  logic [SLOT_W-1:0] slot_reg;
  logic [TDATA_W-1:0] pack_reg;
  logic             overflow_reg;
  logic [15:0]      frame_cnt_reg;

  // Output FIFO: memory plus one output register. Occupancy counts both so
  // that the total capacity is exactly FIFO_DEPTH beats.
  logic [TDATA_W:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]        mem_cnt_reg;
  logic [AW:0]        occ;
  logic               tvalid_reg;
  logic               tlast_reg;
  logic [TDATA_W-1:0] tdata_reg;

  logic start_ok;
  logic trig_edge;
  logic keep;
  logic last_inst;
  logic beat_done;
  logic push;
  logic pop;
  logic full;
  logic push_ok;
  logic push_drop;
  logic frame_done;
  logic load;

  logic [15:0]        ext [CH_NUM];
  logic [TDATA_W-1:0] beat_data;

  // -------------------------------------------------------------------------
  // Sign extension of each channel into a 16-bit lane value
  // -------------------------------------------------------------------------
  genvar gi, gj;
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_ext
      logic [SAMPLE_W-1:0] raw;
      assign raw = ad_data[gi*SAMPLE_W +: SAMPLE_W];
      if (SAMPLE_W < 16) begin : g_sx
        assign ext[gi] = {{(16-SAMPLE_W){raw[SAMPLE_W-1]}}, raw};
      end else begin : g_nx
        assign ext[gi] = raw;
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Beat assembly: the current slot's lanes take the live samples, the rest
  // come from the packing register. Slots beyond the current one are still
  // zero there, which is what fills a partial final beat.
  // -------------------------------------------------------------------------
  generate
    for (gi = 0; gi < K; gi++) begin : g_slot
      for (gj = 0; gj < CH_NUM; gj++) begin : g_ch
        localparam int LANE = gi * CH_NUM + gj;
        assign beat_data[16*LANE +: 16] =
          (slot_reg == SLOT_W'(gi)) ? ext[gj] : pack_reg[16*LANE +: 16];
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Control decode
  // -------------------------------------------------------------------------
  assign start_ok   = start && (state_reg == IDLE) && (frame_len != '0);
  assign trig_edge  = trig_in && !trig_prev_reg;
  assign keep       = (state_reg == CAPT) && ad_valid && (dec_cnt_reg == 8'd0);
  assign last_inst  = (inst_cnt_reg == frame_len_reg - LEN_W'(1));
  assign beat_done  = (slot_reg == SLOT_W'(K-1)) || last_inst;
  assign push       = keep && beat_done;

  assign pop        = tvalid_reg && m_axis_tready;
  assign occ        = mem_cnt_reg + (AW+1)'(tvalid_reg);
  assign full       = (occ == (AW+1)'(FIFO_DEPTH));
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push_ok    = push && (!full || pop);
  assign push_drop  = push && full && !pop;
  assign frame_done = push_ok && last_inst;
  assign load       = (mem_cnt_reg != '0) && (!tvalid_reg || m_axis_tready);

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start_ok) state_next = ARM;
      end
      ARM: begin
        if (stop)                              state_next = IDLE;
        else if (!trig_mode_reg || trig_edge)  state_next = CAPT;
      end
      CAPT: begin
        if (push_drop) begin
          state_next = IDLE;
        end else if (frame_done) begin
          // A stop arriving on the final instant still ends the run.
          state_next = (cont_reg && !stop) ? ARM : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Configuration, status and trigger edge detector
  // -------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cont_reg      <= 1'b0;
      trig_mode_reg <= 1'b0;
      decim_reg     <= 8'd0;
      frame_len_reg <= '0;
      trig_prev_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      frame_cnt_reg <= 16'd0;
    end else begin
      // Sampling trig_in during the start cycle means a level that is
      // already high when ARM is entered is not seen as an edge.
      trig_prev_reg <= trig_in;
      if (start_ok) begin
        cont_reg      <= cont;
        trig_mode_reg <= trig_mode;
        decim_reg     <= decim;
        frame_len_reg <= frame_len;
        overflow_reg  <= 1'b0;
        frame_cnt_reg <= 16'd0;
      end else begin
        if (state_reg == CAPT && stop) cont_reg <= 1'b0;
        if (push_drop)                 overflow_reg <= 1'b1;
        if (frame_done)                frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Decimation and packing. All of it is held cleared outside CAPT, so each
  // frame (and each re-arm in continuous mode) starts from a clean state.
  // -------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      dec_cnt_reg  <= 8'd0;
      inst_cnt_reg <= '0;
      slot_reg     <= '0;
      pack_reg     <= '0;
    end else if (state_reg != CAPT) begin
      dec_cnt_reg  <= 8'd0;
      inst_cnt_reg <= '0;
      slot_reg     <= '0;
      pack_reg     <= '0;
    end else begin
      if (ad_valid) begin
        dec_cnt_reg <= (dec_cnt_reg == decim_reg) ? 8'd0 : dec_cnt_reg + 8'd1;
      end
      if (keep) begin
        inst_cnt_reg <= inst_cnt_reg + LEN_W'(1);
        if (beat_done) begin
          slot_reg <= '0;
          pack_reg <= '0;
        end else begin
          slot_reg <= slot_reg + SLOT_W'(1);
          pack_reg <= beat_data;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output FIFO
  // -------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (push_ok) mem[wr_ptr_reg] <= {last_inst, beat_data};
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      mem_cnt_reg <= '0;
      tvalid_reg  <= 1'b0;
      tlast_reg   <= 1'b0;
      tdata_reg   <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      // The output register only reloads when empty or being consumed,
      // which keeps tdata/tlast stable under backpressure.
      if (load) begin
        rd_ptr_reg             <= rd_ptr_reg + AW'(1);
        {tlast_reg, tdata_reg} <= mem[rd_ptr_reg];
        tvalid_reg             <= 1'b1;
      end else if (pop) begin
        tvalid_reg <= 1'b0;
      end
      case ({push_ok, load})
        2'b10:   mem_cnt_reg <= mem_cnt_reg + (AW+1)'(1);
        2'b01:   mem_cnt_reg <= mem_cnt_reg - (AW+1)'(1);
        default: mem_cnt_reg <= mem_cnt_reg;
      endcase
    end
  end

  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tvalid = tvalid_reg;
  assign m_axis_tlast  = tlast_reg;
  assign busy          = (state_reg != IDLE);
  assign overflow      = overflow_reg;
  assign frame_cnt     = frame_cnt_reg;

endmodule

// File: tb/tb_adc_stream_capture.sv
// ---------------------------------------------------------------------------
// tb_adc_stream_capture
//
// Directed bench for adc_stream_capture (CH_NUM=2, SAMPLE_W=12, TDATA_W=64,
// FIFO_DEPTH=16). Instant n carries ch0=n+1, ch1=0x800+n+1; expected beats
// are hand-computed constants. Received beats are logged one per line.
// ---------------------------------------------------------------------------
module tb_adc_stream_capture;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [23:0] ad_data;
  logic        ad_valid;
  logic        start;
  logic        stop;
  logic        cont;
  logic        trig_mode;
  logic        trig_in;
  logic [7:0]  decim;
  logic [15:0] frame_len;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        busy;
  logic        overflow;
  logic [15:0] frame_cnt;

  int checks   = 0;
  int failures = 0;

  logic [64:0] beats [$];

  always #5 sys_clk = ~sys_clk;

  adc_stream_capture #(
    .CH_NUM    (2),
    .SAMPLE_W  (12),
    .TDATA_W   (64),
    .FIFO_DEPTH(16),
    .LEN_W     (16)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .ad_data      (ad_data),
    .ad_valid     (ad_valid),
    .start        (start),
    .stop         (stop),
    .cont         (cont),
    .trig_mode    (trig_mode),
    .trig_in      (trig_in),
    .decim        (decim),
    .frame_len    (frame_len),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .busy         (busy),
    .overflow     (overflow),
    .frame_cnt    (frame_cnt)
  );

  // Transfers complete on the next rising edge; inputs only change just
  // after rising edges, so the falling edge sees the settled handshake.
  always @(negedge sys_clk) begin
    if (!sys_rst && m_axis_tvalid && m_axis_tready) begin
      beats.push_back({m_axis_tlast, m_axis_tdata});
      $display("beat %0d tdata=%016h tlast=%0d", beats.size() - 1,
               m_axis_tdata, m_axis_tlast);
    end
  end

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic c, input logic tm, input logic [7:0] d,
                          input logic [15:0] len);
    @(posedge sys_clk); #1;
    cont = c; trig_mode = tm; decim = d; frame_len = len; start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    @(posedge sys_clk); #1;
  endtask

  // Drives n consecutive valid instants numbered from 0; stop is pulsed
  // alongside instant stop_at (use -1 for none).
  task automatic feed(input int n, input int stop_at);
    logic [11:0] c0, c1;
    for (int i = 0; i < n; i++) begin
      c0 = i[11:0] + 12'd1;
      c1 = i[11:0] + 12'h801;
      ad_data  = {c1, c0};
      ad_valid = 1'b1;
      stop     = (i == stop_at);
      @(posedge sys_clk); #1;
    end
    ad_valid = 1'b0;
    stop     = 1'b0;
    ad_data  = '0;
  endtask

  // Waits until the FSM is idle and no transfer has happened for several
  // cycles in a row, with a bounded budget.
  task automatic wait_quiet(input string tag);
    int  quiet;
    logic ok;
    quiet = 0;
    ok    = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge sys_clk);
      if (!busy && !(m_axis_tvalid && m_axis_tready)) quiet++;
      else quiet = 0;
      if (quiet >= 6) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, ok, 1'b1);
    @(posedge sys_clk); #1;
  endtask

  int n_last;

  initial begin
    sys_rst = 1'b1;
    ad_data = '0; ad_valid = 1'b0; start = 1'b0; stop = 1'b0;
    cont = 1'b0; trig_mode = 1'b0; trig_in = 1'b0; decim = 8'd0;
    frame_len = 16'd0; m_axis_tready = 1'b1;

    // Reset state
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tdata", m_axis_tdata, 64'd0);
    check("rst_tlast", m_axis_tlast, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_frame_cnt", frame_cnt, 16'd0);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;

    // Ignored start: frame_len = 0
    do_start(1'b0, 1'b0, 8'd0, 16'd0);
    check("len0_busy", busy, 1'b0);

    // Basic frame, frame_len=4
    beats.delete();
    @(posedge sys_clk); #1;
    cont = 1'b0; trig_mode = 1'b0; decim = 8'd0; frame_len = 16'd4; start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    check("t1_busy_after_start", busy, 1'b1);
    @(posedge sys_clk); #1;
    feed(4, -1);
    wait_quiet("t1_quiet");
    check("t1_nbeats", beats.size(), 2);
    check("t1_beat0", beats[0], {1'b0, 64'hF802_0002_F801_0001});
    check("t1_beat1", beats[1], {1'b1, 64'hF804_0004_F803_0003});
    check("t1_frame_cnt", frame_cnt, 16'd1);
    check("t1_busy", busy, 1'b0);

    // Partial final beat, frame_len=3
    beats.delete();
    do_start(1'b0, 1'b0, 8'd0, 16'd3);
    feed(3, -1);
    wait_quiet("t2_quiet");
    check("t2_nbeats", beats.size(), 2);
    check("t2_beat0", beats[0], {1'b0, 64'hF802_0002_F801_0001});
    check("t2_beat1", beats[1], {1'b1, 64'h0000_0000_F803_0003});
    check("t2_frame_cnt", frame_cnt, 16'd1);

    // Decimation by 3: instants 0, 3, 6, 9 kept
    beats.delete();
    do_start(1'b0, 1'b0, 8'd2, 16'd4);
    feed(12, -1);
    wait_quiet("t3_quiet");
    check("t3_nbeats", beats.size(), 2);
    check("t3_beat0", beats[0], {1'b0, 64'hF804_0004_F801_0001});
    check("t3_beat1", beats[1], {1'b1, 64'hF80A_000A_F807_0007});

    // External trigger held high at arm time does not fire
    beats.delete();
    trig_in = 1'b1;
    do_start(1'b0, 1'b1, 8'd0, 16'd4);
    feed(4, -1);
    repeat (4) @(posedge sys_clk);
    #1;
    check("t4_no_beats", beats.size(), 0);
    check("t4_busy_armed", busy, 1'b1);
    trig_in = 1'b0;
    @(posedge sys_clk); #1;
    trig_in = 1'b1;
    @(posedge sys_clk); #1;
    feed(4, -1);
    trig_in = 1'b0;
    wait_quiet("t4_quiet");
    check("t4_nbeats", beats.size(), 2);
    check("t4_beat0", beats[0], {1'b0, 64'hF802_0002_F801_0001});
    check("t4_beat1", beats[1], {1'b1, 64'hF804_0004_F803_0003});

    // Overflow: 16-deep FIFO, no ready, 32 beats offered
    beats.delete();
    m_axis_tready = 1'b0;
    do_start(1'b0, 1'b0, 8'd0, 16'd64);
    feed(64, -1);
    wait_quiet("t5_quiet");
    check("t5_overflow", overflow, 1'b1);
    check("t5_busy", busy, 1'b0);
    check("t5_frame_cnt", frame_cnt, 16'd0);
    check("t5_tvalid_held", m_axis_tvalid, 1'b1);
    check("t5_tdata_held", m_axis_tdata, 64'hF802_0002_F801_0001);
    m_axis_tready = 1'b1;
    wait_quiet("t5_drain");
    check("t5_nbeats", beats.size(), 16);
    n_last = 0;
    foreach (beats[i]) if (beats[i][64]) n_last++;
    check("t5_no_tlast", n_last, 0);
    check("t5_beat0", beats[0], {1'b0, 64'hF802_0002_F801_0001});
    check("t5_beat15", beats[15], {1'b0, 64'hF820_0020_F81F_001F});

    // Continuous frames, stop during frame 3 (start also clears overflow)
    beats.delete();
    do_start(1'b1, 1'b0, 8'd0, 16'd2);
    check("t6_overflow_cleared", overflow, 1'b0);
    feed(12, 6);
    wait_quiet("t6_quiet");
    check("t6_nbeats", beats.size(), 3);
    check("t6_beat0", beats[0], {1'b1, 64'hF802_0002_F801_0001});
    check("t6_beat1", beats[1], {1'b1, 64'hF805_0005_F804_0004});
    check("t6_beat2", beats[2], {1'b1, 64'hF808_0008_F807_0007});
    check("t6_frame_cnt", frame_cnt, 16'd3);
    check("t6_busy", busy, 1'b0);

    // Asynchronous reset mid-frame
    beats.delete();
    m_axis_tready = 1'b0;
    do_start(1'b1, 1'b0, 8'd0, 16'd2);
    feed(4, -1);
    check("t7_pre_tvalid", m_axis_tvalid, 1'b1);
    check("t7_pre_busy", busy, 1'b1);
    sys_rst = 1'b1;
    #1;
    check("t7_rst_tvalid", m_axis_tvalid, 1'b0);
    check("t7_rst_busy", busy, 1'b0);
    check("t7_rst_frame_cnt", frame_cnt, 16'd0);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge sys_clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_stream_capture.md
# adc_stream_capture

Parametrised multi-channel ADC capture engine that converts per-sample ADC words into AXI-Stream frames for the DMA S2MM path in the role. It sits between the ADC front-end (already retimed into the system clock domain) and `m_axis_s2mm`. It adds the following to the fixed two-channel 12-bit front-end:
- configurable channel count and sample width;
- decimation;
- an external trigger;
- continuous-frame mode;
- an output FIFO with overflow detection.

## Interface
Parameters:
- CH_NUM, 2, number of ADC channels; (TDATA_W/16) must be a multiple of CH_NUM
- SAMPLE_W, 12, ADC sample width, 1..16; each sample is sign-extended to a 16-bit lane
- TDATA_W, 64, stream data width; multiple of 16
- FIFO_DEPTH, 512, output FIFO depth in beats; power of two, at least 4
- LEN_W, 16, width of frame_len

Derived: K = TDATA_W/(16*CH_NUM), the number of sample instants per beat.

Ports (one clock; reset is asynchronous and active-high):
- sys_clk  in  1  system clock; all logic in this domain
- sys_rst  in  1  asynchronous active-high reset
- ad_data  in  CH_NUM*SAMPLE_W  channel c occupies bits [c*SAMPLE_W +: SAMPLE_W]
- ad_valid  in  1  one sample instant on ad_data this cycle
- start  in  1  pulse; latches configuration and leaves IDLE
- stop  in  1  pulse; ends capture (see Operation)
- cont  in  1  1 = repeat frames until stop
- trig_mode  in  1  0 = immediate, 1 = wait for rising edge of trig_in
- trig_in  in  1  external trigger, synchronous to sys_clk
- decim  in  8  keep 1 of every decim+1 valid instants
- frame_len  in  LEN_W  sample instants per frame
- m_axis_tdata  out  TDATA_W  packed samples
- m_axis_tvalid  out  1  AXI-Stream valid
- m_axis_tready  in  1  AXI-Stream ready
- m_axis_tlast  out  1  last beat of a frame
- busy  out  1  FSM not IDLE
- overflow  out  1  sticky; cleared only by start
- frame_cnt  out  16  completed frames since the last start; wraps

## Operation
- FSM states: IDLE, ARM, CAPT.
  - IDLE→ARM on start, when frame_len≠0. A start with frame_len=0 is ignored.
  - ARM→CAPT on the cycle after ARM entry if trig_mode=0.
  - If trig_mode=1, ARM→CAPT on the first cycle with trig_in=1 and the previous trig_in=0. A trigger level already high at arm time does not fire.
  - CAPT→ARM at frame end when the latched cont=1; otherwise CAPT→IDLE.
- Configuration latching:
  - start latches cont, trig_mode, decim and frame_len, clears overflow and frame_cnt, and restarts the trig_in edge detector.
  - Changes to these inputs while busy have no effect.
- Decimation:
  - A counter counts ad_valid instants in CAPT only. It resets to 0 on CAPT entry.
  - An instant is kept when the counter is 0. The counter wraps at decim.
  - The first valid instant in CAPT is always kept.
- Packing:
  - A kept instant i (0-based within the frame) writes lane (i mod K)*CH_NUM + c with sign-extended channel c.
  - Lane L is bits [16L +: 16].
  - A beat is pushed after K kept instants, or after the final instant of the frame.
- Partial final beat:
  - When frame_len is not a multiple of K, the unfilled lanes of the final beat are 0.
  - Beats per frame = ceil(frame_len/K). The final beat carries tlast=1.
- FIFO:
  - Stores {tlast, tdata}; first-word-fall-through to m_axis.
  - A beat transfers when tvalid&&tready.
- Overflow:
  - A push with the FIFO full drops that beat and sets overflow.
  - The FSM goes to IDLE; the frame is aborted with no tlast, and frame_cnt is not incremented.
  - Beats already queued still drain.
- Stop:
  - In ARM: go to IDLE next cycle.
  - In CAPT: clear the latched cont; the current frame completes normally.
  - Stop in the same cycle as start: start wins and stop is ignored.
- frame_cnt increments when the tlast beat is pushed into the FIFO.
- Reset:
  - Asynchronous; clears the FSM, counters, packer and FIFO pointers.
  - A frame in flight is discarded.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, busy=0, overflow=0, frame_cnt=0.
- busy rises on the cycle after start.
- Latency: a beat completed by the kept instant at cycle t is in the FIFO at t+1, with m_axis_tvalid=1 at t+2 if the FIFO was empty.
- Throughput: one kept instant per cycle sustained. The FIFO accepts one push and one pop in the same cycle, including when full: a pop and a push in the same cycle is not an overflow.
- tdata and tlast are stable while tvalid=1 && tready=0.
- A trig_in edge is detected on the cycle it is sampled high.

## Test plan
- Defaults (K=2); frame_len=4, decim=0, trig_mode=0, tready=1; instant n has ch0=n+1 and ch1=0x800+n+1. Expect two beats: 0xF802_0002_F801_0001 with tlast=0, then 0xF804_0004_F803_0003 with tlast=1. frame_cnt=1, busy=0 afterwards.
- frame_len=3 with the same data. Expect beat 2 = 0x0000_0000_F803_0003 with tlast=1.
- decim=2, 12 valid instants, frame_len=4. Instants 0, 3, 6 and 9 are captured; ch0 lanes across both beats read 1, 4, 7, 10.
- trig_mode=1 with trig_in held high at start. No beats appear; busy=1. After trig_in 0→1, capture begins on the first valid instant.
- FIFO_DEPTH=16, tready=0, frame_len=64. 16 beats are stored, the 17th is dropped, overflow=1 and busy=0. After tready=1, exactly 16 beats arrive, none with tlast. A subsequent start clears overflow.
- cont=1, frame_len=2, stop pulsed mid-frame 3. Frame 3 completes with tlast, frame_cnt=3, then IDLE. Assert sys_rst mid-frame in a rerun: tvalid=0 and busy=0 immediately.
